// File: rtl/pkt_rr_allocator.sv
// Output-port allocator: round-robin over L/W/S header flits, port locked to the winner until its last flit.
// Latency: grant/sel are combinational in the request cycle; state, ptr, cnt, pkt_count update on that edge.
// Backpressure: dcts=0 or owner req=0 stalls the packet with sel held; cnt and state are frozen.
module pkt_rr_allocator #(
    parameter int          LEN_W     = 12,
    parameter logic [2:0]  FT_HEADER = 3'b001,
    parameter logic [2:0]  FT_BODY   = 3'b010,
    parameter logic [2:0]  FT_TAIL   = 3'b100,
    parameter int          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         req,
    input  logic [8:0]         flit_type,
    input  logic [3*LEN_W-1:0] len,
    input  logic               dcts,
    output logic [2:0]         grant,
    output logic [2:0]         sel,
    output logic               valid,
    output logic               busy,
    output logic               len_err,
    output logic [CNT_W-1:0]   pkt_count
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         owner_q, owner_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               len_err_q, len_err_d;
    logic [CNT_W-1:0]   pkt_q, pkt_d;

    logic [2:0]         ft_a  [3];
    logic [LEN_W-1:0]   len_a [3];
    logic [2:0]         elig;
    logic               found;
    logic [1:0]         win;
    logic [1:0]         cand;
    logic [2:0]         own_ft;
    logic [2:0]         grant_c, sel_c;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] p);
        return 3'b001 << p;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ft_a[i]  = flit_type[3*i +: 3];
            len_a[i] = len[LEN_W*i +: LEN_W];
            elig[i]  = req[i] && (flit_type[3*i +: 3] == FT_HEADER);
        end
    end

    // First eligible input walking ptr, ptr+1, ptr+2 (mod 3).
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < 3; k++) begin
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
            cand = inc3(cand);
        end
    end

    // Inside a packet a stray header code from the owner counts as body.
    assign own_ft = (ft_a[owner_q] == FT_HEADER) ? FT_BODY : ft_a[owner_q];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        pkt_d     = pkt_q;
        len_err_d = 1'b0;
        grant_c   = 3'b000;
        sel_c     = 3'b000;
        case (state_q)
            IDLE: begin
                if (found && dcts) begin
                    grant_c = onehot3(win);
                    sel_c   = grant_c;
                    if (len_a[win] == '0) begin
                        ptr_d = inc3(win);
                        pkt_d = pkt_q + 1'b1;
                    end else begin
                        state_d = BUSY;
                        owner_d = win;
                        cnt_d   = len_a[win];
                    end
                end
            end
            BUSY: begin
                sel_c = onehot3(owner_q);
                if (req[owner_q] && dcts) begin
                    grant_c = sel_c;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1) || own_ft == FT_TAIL) begin
                        state_d   = IDLE;
                        ptr_d     = inc3(owner_q);
                        pkt_d     = pkt_q + 1'b1;
                        len_err_d = (cnt_q != LEN_W'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            owner_q   <= 2'd0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
            pkt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
            pkt_q     <= pkt_d;
        end
    end

    // Combinational grant path is gated so nothing is read while reset is held.
    assign grant     = rst ? grant_c : 3'b000;
    assign sel       = rst ? sel_c   : 3'b000;
    assign valid     = |grant;
    assign busy      = (state_q == BUSY);
    assign len_err   = len_err_q;
    assign pkt_count = pkt_q;

endmodule

// File: tb/tb_pkt_rr_allocator.sv
// Bench for pkt_rr_allocator: per-input flit queues feed the DUT; a packet-level model predicts every cycle.
module tb_pkt_rr_allocator;

    localparam int         LEN_W = 12;
    localparam int         CNT_W = 16;
    localparam logic [2:0] HDR   = 3'b001;
    localparam logic [2:0] BODY  = 3'b010;
    localparam logic [2:0] TAIL  = 3'b100;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [2:0]         req = '0;
    logic [8:0]         flit_type = '0;
    logic [3*LEN_W-1:0] len = '0;
    logic               dcts = 1'b0;
    logic [2:0]         grant, sel;
    logic               valid, busy, len_err;
    logic [CNT_W-1:0]   pkt_count;

    pkt_rr_allocator dut (
        .clk(clk), .rst(rst), .req(req), .flit_type(flit_type), .len(len), .dcts(dcts),
        .grant(grant), .sel(sel), .valid(valid), .busy(busy), .len_err(len_err),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    int fq [3][$];
    int lq [3][$];
    logic [2:0] req_mask = 3'b111;

    // Packet-level model: who holds the port, flits still owed, next input to favour.
    bit               m_busy;
    int               m_owner, m_rem, m_ptr;
    logic [CNT_W-1:0] m_pkts;
    bit               m_lerr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_rem = 0; m_ptr = 0; m_pkts = '0; m_lerr = 0;
    endtask

    // tail_at>0 ends the packet early with a tail as flit number tail_at.
    task automatic push_pkt(input int i, input int l, input int tail_at, input bit noise);
        int n;
        int t;
        n = (tail_at > 0) ? tail_at : l + 1;
        for (int f = 0; f < n; f++) begin
            if (f == 0)           t = HDR;
            else if (f == n - 1)  t = TAIL;
            else if (noise && ($urandom % 8 == 0)) t = HDR;
            else                  t = BODY;
            fq[i].push_back(t);
            lq[i].push_back(l);
        end
    endtask

    task automatic clear_queues();
        for (int i = 0; i < 3; i++) begin
            fq[i].delete();
            lq[i].delete();
        end
    endtask

    task automatic drive();
        logic [2:0]         r;
        logic [8:0]         ft;
        logic [3*LEN_W-1:0] ln;
        r = '0; ft = '0; ln = '0;
        for (int i = 0; i < 3; i++) begin
            if (fq[i].size() > 0) begin
                r[i]              = req_mask[i];
                ft[3*i +: 3]      = 3'(fq[i][0]);
                ln[LEN_W*i +: LEN_W] = LEN_W'(lq[i][0]);
            end
        end
        req = r; flit_type = ft; len = ln;
    endtask

    task automatic cycle();
        int         win;
        int         hl;
        int         t;
        logic [2:0] eg, es;
        bit         lerr_n;
        drive();
        if (!rst) model_reset();
        win = -1; eg = '0; es = '0;
        if (rst) begin
            if (!m_busy) begin
                for (int k = 0; k < 3; k++) begin
                    int i;
                    i = (m_ptr + k) % 3;
                    if (win < 0 && req[i] && fq[i].size() > 0 && fq[i][0] == HDR) win = i;
                end
                if (win >= 0 && dcts) begin
                    eg = 3'b001 << win;
                    es = eg;
                end
            end else begin
                es = 3'b001 << m_owner;
                if (req[m_owner] && dcts) eg = es;
            end
        end
        @(negedge clk);
        check("grant",     32'(grant),     32'(eg));
        check("sel",       32'(sel),       32'(es));
        check("valid",     32'(valid),     32'(|eg));
        check("busy",      32'(busy),      32'(m_busy));
        check("len_err",   32'(len_err),   32'(m_lerr));
        check("pkt_count", 32'(pkt_count), 32'(m_pkts));
        @(posedge clk);
        lerr_n = 0;
        if (rst && eg != 0) begin
            if (!m_busy) begin
                hl = lq[win][0];
                void'(fq[win].pop_front());
                void'(lq[win].pop_front());
                if (hl == 0) begin
                    m_ptr  = (win + 1) % 3;
                    m_pkts = m_pkts + 1'b1;
                end else begin
                    m_busy  = 1;
                    m_owner = win;
                    m_rem   = hl;
                end
            end else begin
                t = fq[m_owner][0];
                void'(fq[m_owner].pop_front());
                void'(lq[m_owner].pop_front());
                if (m_rem == 1 || t == TAIL) begin
                    lerr_n = (m_rem != 1);
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % 3;
                    m_pkts = m_pkts + 1'b1;
                end else begin
                    m_rem = m_rem - 1;
                end
            end
        end
        m_lerr = rst ? lerr_n : 1'b0;
        #1;
    endtask

    // Reset lands between edges while the port is mid-packet.
    task automatic async_reset_mid();
        drive();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("arst_grant",     32'(grant),     32'(0));
        check("arst_sel",       32'(sel),       32'(0));
        check("arst_valid",     32'(valid),     32'(0));
        check("arst_busy",      32'(busy),      32'(0));
        check("arst_pkt_count", 32'(pkt_count), 32'(m_pkts));
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        dcts = 1'b1;
        req_mask = 3'b111;
        for (int i = 0; i < 3; i++) push_pkt(i, 2, 0, 0);
        repeat (2) cycle();
        rst = 1'b1;
        repeat (10) cycle();

        push_pkt(1, 3, 0, 0);
        repeat (2) cycle();
        dcts = 1'b0;
        repeat (4) cycle();
        dcts = 1'b1;
        repeat (4) cycle();

        push_pkt(0, 0, 0, 0);
        push_pkt(2, 5, 3, 0);
        repeat (7) cycle();

        push_pkt(2, 4, 0, 0);
        req_mask = 3'b100;
        repeat (3) cycle();
        async_reset_mid();
        cycle();
        clear_queues();
        req_mask = 3'b111;
        for (int i = 0; i < 3; i++) push_pkt(i, 1, 0, 0);
        rst = 1'b1;
        repeat (8) cycle();

        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (fq[i].size() < 4 && ($urandom % 3 == 0)) begin
                    int l;
                    int ta;
                    l  = $urandom % 5;
                    ta = (l >= 2 && ($urandom % 4 == 0)) ? int'($urandom_range(l, 2)) : 0;
                    push_pkt(i, l, ta, 1);
                end
            end
            req_mask = 3'($urandom);
            dcts     = ($urandom % 4) != 0;
            cycle();
        end

        req_mask = 3'b111;
        dcts     = 1'b1;
        repeat (60) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
